player_bullet: RTL and testbench
================================

Name: player_bullet

Overview:
- Transmitter side of the bullet/collision interface. Launches a single player shot from the ship position when the player fires.
- Moves the shot upward once per frame and drives bullet_x, bullet_y and bullet_active to every alien instance.
- Retires the shot when it leaves the screen or when the top-level collision logic returns a hit.
- Also renders the bullet pixel for the video mixer.

Parameters:
BULLET_W, 4, bullet width in pixels (even)
BULLET_H, 10, bullet height in pixels
BULLET_SPEED, 8, pixels moved up per frame
COOLDOWN_FRAMES, 15, frames after retire before the next launch is allowed
BULLET_COLOR, 24'hFFFF00, RGB888 colour

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  reset
fsync  in  1  one-cycle frame-start pulse
hpos  in  12 signed  current pixel x
vpos  in  12 signed  current pixel y
fire  in  1  fire button level, already synchronous and debounced
player_x  in  12 signed  ship centre x
player_y  in  12 signed  ship top y
hit  in  1  one-cycle pulse: in-flight bullet struck an alien
bullet_x  out  12 signed  bullet centre x
bullet_y  out  12 signed  bullet top y
bullet_active  out  1  bullet in flight
shots_fired  out  8  launch count, wraps 255->0
pixel  out  8 x [0:2]  RGB (pixel[2]=R, pixel[1]=G, pixel[0]=B)
active  out  1  current pixel is bullet

Behaviour:
- Reset: reset rst, synchronous, active-high; clock pixel_clk.
  - State=IDLE; bullet_x=0, bullet_y=0, bullet_active=0, shots_fired=0.
  - fire_req=0, fire_d=0, cooldown count=0.
- Fire edge: fire_d registers fire every clock. Rising edge = fire & ~fire_d.
  - Edge in IDLE or COOLDOWN sets fire_req.
  - Edge in FLYING is ignored, not queued.
- FSM, evaluated every pixel_clk:
  - IDLE: on fsync with fire_req (or a rising edge in this same cycle):
    - bullet_x<=player_x; bullet_y<=player_y-BULLET_H; bullet_active<=1.
    - shots_fired++, fire_req<=0, ->FLYING.
  - FLYING, priority order:
    1. hit=1: bullet_active<=0, count<=COOLDOWN_FRAMES, ->COOLDOWN. hit wins over a coincident fsync; no move that cycle.
    2. fsync and (bullet_y-BULLET_SPEED < 0): retire the same way as hit.
    3. fsync otherwise: bullet_y<=bullet_y-BULLET_SPEED; bullet_x holds (does not track the player).
  - COOLDOWN:
    - count==0: ->IDLE on the next clock. With COOLDOWN_FRAMES=0 this gives a one-cycle COOLDOWN.
    - Otherwise count decrements on each fsync.
    - A fire edge here is latched into fire_req and launches at the first IDLE fsync.
- hit outside FLYING is ignored.
- Arithmetic: 12-bit signed; comparison against 0 is signed, so a result of -1 retires.
- bullet_x/bullet_y keep their last values when inactive. Consumers must gate on bullet_active.
- Render (combinational, zero latency), active=1 when all hold:
  - bullet_active;
  - bullet_x-BULLET_W/2 <= hpos <= bullet_x+BULLET_W/2-1;
  - bullet_y <= vpos <= bullet_y+BULLET_H-1.
  - pixel = BULLET_COLOR bytes when active, else 0.
- Reset mid-flight: bullet disappears the next cycle and any pending fire_req is lost.

Optional Feature:
BULLET_AUTOFIRE_EN
- Defined: in IDLE, fire held high at fsync is itself a launch request. Holding fire repeats one shot per (flight + cooldown).
- Undefined: only rising edges request. The player must release and re-press fire.

Test Plan:
- Reset, then player_x=320, player_y=440, fire pulse, fsync -> bullet_active=1, bullet_x=320, bullet_y=430, shots_fired=1.
- Let it fly with no hit -> bullet_y steps 430,422,...,6. The next fsync retires it (6-8<0). 15 fsyncs later FSM is IDLE and a new fire launches.
- Flying bullet, hit pulse coincident with fsync at bullet_y=200 -> bullet_y stays 200, bullet_active=0 the next cycle, FSM=COOLDOWN.
- Fire edge during FLYING -> no second launch after retire. Fire edge during COOLDOWN -> launch at the first IDLE fsync, shots_fired increments by 1.
- Render: bullet at (100,50) -> active=1 for hpos 98..101, vpos 50..59 with pixel=FF,FF,00; active=0 at hpos 97, hpos 102 and vpos 60.
- Reset asserted mid-flight -> the next cycle gives bullet_active=0, shots_fired=0, active=0. With BULLET_AUTOFIRE_EN, fire held constantly -> shots_fired increments once per flight+cooldown period.

Source files
------------

// File: rtl/player_bullet.sv
// Player shot launcher/mover and bullet sprite renderer for the alien-collision interface.
// Optional macro BULLET_AUTOFIRE_EN: holding fire in IDLE requests a launch at every frame start.
module player_bullet #(
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 10,
    parameter int          BULLET_SPEED    = 8,
    parameter int          COOLDOWN_FRAMES = 15,
    parameter logic [23:0] BULLET_COLOR    = 24'hFFFF00
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic               fire,
    input  logic signed [11:0] player_x,
    input  logic signed [11:0] player_y,
    input  logic               hit,
    output logic signed [11:0] bullet_x,
    output logic signed [11:0] bullet_y,
    output logic               bullet_active,
    output logic [7:0]         shots_fired,
    output logic [7:0]         pixel [0:2],
    output logic               active
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic signed [11:0] SPEED_S  = 12'(BULLET_SPEED);
    localparam logic signed [11:0] HEIGHT_S = 12'(BULLET_H);
    localparam logic signed [12:0] HALF_W13 = 13'(BULLET_W / 2);
    localparam logic signed [12:0] H13      = 13'(BULLET_H);
    localparam logic signed [12:0] ONE13    = 13'sd1;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLDOWN
    } state_t;

    state_t             state;
    logic               fire_d;
    logic               fire_req;
    logic [CNT_W-1:0]   cooldown_cnt;

    logic               fire_edge;
    logic               launch_req;
    logic signed [11:0] step_y;
    logic signed [11:0] launch_y;
    logic               off_top;

    assign fire_edge = fire & ~fire_d;

`ifdef BULLET_AUTOFIRE_EN
    assign launch_req = fire_req | fire_edge | fire;
`else
    assign launch_req = fire_req | fire_edge;
`endif

    assign step_y   = bullet_y - SPEED_S;
    assign launch_y = player_y - HEIGHT_S;
    assign off_top  = (step_y < 12'sd0);

    // Shot life cycle; fire edges seen while FLYING are dropped, never queued.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state         <= IDLE;
            bullet_x      <= '0;
            bullet_y      <= '0;
            bullet_active <= 1'b0;
            shots_fired   <= '0;
            fire_req      <= 1'b0;
            fire_d        <= 1'b0;
            cooldown_cnt  <= '0;
        end else begin
            fire_d <= fire;
            case (state)
                IDLE: begin
                    if (fsync && launch_req) begin
                        bullet_x      <= player_x;
                        bullet_y      <= launch_y;
                        bullet_active <= 1'b1;
                        shots_fired   <= shots_fired + 8'd1;
                        fire_req      <= 1'b0;
                        state         <= FLYING;
                    end else if (fire_edge) begin
                        fire_req <= 1'b1;
                    end
                end
                FLYING: begin
                    if (hit || (fsync && off_top)) begin
                        bullet_active <= 1'b0;
                        cooldown_cnt  <= CNT_W'(COOLDOWN_FRAMES);
                        state         <= COOLDOWN;
                    end else if (fsync) begin
                        bullet_y <= step_y;
                    end
                end
                COOLDOWN: begin
                    if (fire_edge) begin
                        fire_req <= 1'b1;
                    end
                    if (cooldown_cnt == '0) begin
                        state <= IDLE;
                    end else if (fsync) begin
                        cooldown_cnt <= cooldown_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sprite bounds are widened to 13 bits so edge-of-range positions cannot wrap.
    logic signed [12:0] bx;
    logic signed [12:0] by;
    logic signed [12:0] hx;
    logic signed [12:0] vy;
    logic signed [12:0] x_lo;
    logic signed [12:0] x_hi;
    logic signed [12:0] y_hi;
    logic               in_x;
    logic               in_y;

    assign bx   = {bullet_x[11], bullet_x};
    assign by   = {bullet_y[11], bullet_y};
    assign hx   = {hpos[11], hpos};
    assign vy   = {vpos[11], vpos};
    assign x_lo = bx - HALF_W13;
    assign x_hi = bx + HALF_W13 - ONE13;
    assign y_hi = by + H13 - ONE13;

    assign in_x   = (hx >= x_lo) && (hx <= x_hi);
    assign in_y   = (vy >= by) && (vy <= y_hi);
    assign active = bullet_active && in_x && in_y;

    always_comb begin
        pixel[2] = 8'h00;
        pixel[1] = 8'h00;
        pixel[0] = 8'h00;
        if (active) begin
            pixel[2] = BULLET_COLOR[23:16];
            pixel[1] = BULLET_COLOR[15:8];
            pixel[0] = BULLET_COLOR[7:0];
        end
    end

endmodule

// File: tb/tb_player_bullet.sv
// Directed self-checking bench for player_bullet: launch, flight, hit, cooldown, render, reset.
// Autofire scenario is compiled in when BULLET_AUTOFIRE_EN is defined.
module tb_player_bullet;

    logic               pixel_clk;
    logic               rst;
    logic               fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               fire;
    logic signed [11:0] player_x;
    logic signed [11:0] player_y;
    logic               hit;
    logic signed [11:0] bullet_x;
    logic signed [11:0] bullet_y;
    logic               bullet_active;
    logic [7:0]         shots_fired;
    logic [7:0]         pixel [0:2];
    logic               active;

    int checks = 0;
    int passed = 0;

    player_bullet dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .fsync        (fsync),
        .hpos         (hpos),
        .vpos         (vpos),
        .fire         (fire),
        .player_x     (player_x),
        .player_y     (player_y),
        .hit          (hit),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_active(bullet_active),
        .shots_fired  (shots_fired),
        .pixel        (pixel),
        .active       (active)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One frame: a single-cycle fsync followed by an idle gap cycle.
    task automatic frame();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bullet_active !== 1'b0) $display("FAIL reset_active got=%0b want=0", bullet_active);
        else passed++;
        checks++;
        if (bullet_x !== 12'sd0 || bullet_y !== 12'sd0)
            $display("FAIL reset_xy got=%0d,%0d want=0,0", bullet_x, bullet_y);
        else passed++;
        checks++;
        if (shots_fired !== 8'd0) $display("FAIL reset_shots got=%0d want=0", shots_fired);
        else passed++;
        checks++;
        if (active !== 1'b0 || {pixel[2], pixel[1], pixel[0]} !== 24'h0)
            $display("FAIL reset_render got=%0b/%h want=0/000000", active, {pixel[2], pixel[1], pixel[0]});
        else passed++;
    endtask

    task automatic test_launch();
        player_x = 12'sd320;
        player_y = 12'sd440;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        frame();
        checks++;
        if (bullet_active !== 1'b1 || bullet_x !== 12'sd320 || bullet_y !== 12'sd430 || shots_fired !== 8'd1)
            $display("FAIL launch got=%0b,%0d,%0d,%0d want=1,320,430,1",
                     bullet_active, bullet_x, bullet_y, shots_fired);
        else passed++;
    endtask

    task automatic test_flight();
        int exp_y;
        exp_y = 430;
        for (int k = 0; k < 53; k++) begin
            frame();
            exp_y = exp_y - 8;
            checks++;
            if (bullet_y !== 12'(exp_y) || bullet_active !== 1'b1)
                $display("FAIL flight_step%0d got=%0d,%0b want=%0d,1", k, bullet_y, bullet_active, exp_y);
            else passed++;
        end
        frame();
        checks++;
        if (bullet_active !== 1'b0 || bullet_y !== 12'sd6)
            $display("FAIL flight_retire got=%0b,%0d want=0,6", bullet_active, bullet_y);
        else passed++;
        // 14 frames leave one count; a fire edge on the 15th fsync is latched, not launched.
        frames(14);
        fire  = 1'b1;
        fsync = 1'b1;
        tick();
        fire  = 1'b0;
        fsync = 1'b0;
        tick();
        checks++;
        if (bullet_active !== 1'b0 || shots_fired !== 8'd1)
            $display("FAIL cooldown_hold got=%0b,%0d want=0,1", bullet_active, shots_fired);
        else passed++;
        frame();
        checks++;
        if (bullet_active !== 1'b1 || shots_fired !== 8'd2 || bullet_y !== 12'sd430)
            $display("FAIL cooldown_launch got=%0b,%0d,%0d want=1,2,430", bullet_active, shots_fired, bullet_y);
        else passed++;
    endtask

    task automatic test_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        checks++;
        if (bullet_active !== 1'b0 || bullet_y !== 12'sd430)
            $display("FAIL hit_retire got=%0b,%0d want=0,430", bullet_active, bullet_y);
        else passed++;
        frames(15);
        player_x = 12'sd100;
        player_y = 12'sd210;
        fire  = 1'b1;
        fsync = 1'b1;
        tick();
        fire  = 1'b0;
        fsync = 1'b0;
        tick();
        checks++;
        if (bullet_active !== 1'b1 || bullet_x !== 12'sd100 || bullet_y !== 12'sd200 || shots_fired !== 8'd3)
            $display("FAIL same_cycle_launch got=%0b,%0d,%0d,%0d want=1,100,200,3",
                     bullet_active, bullet_x, bullet_y, shots_fired);
        else passed++;
        hit   = 1'b1;
        fsync = 1'b1;
        tick();
        hit   = 1'b0;
        fsync = 1'b0;
        checks++;
        if (bullet_active !== 1'b0 || bullet_y !== 12'sd200)
            $display("FAIL hit_with_fsync got=%0b,%0d want=0,200", bullet_active, bullet_y);
        else passed++;
        fire  = 1'b1;
        fsync = 1'b1;
        tick();
        fire  = 1'b0;
        fsync = 1'b0;
        tick();
        checks++;
        if (bullet_active !== 1'b0) $display("FAIL hit_in_cooldown got=%0b want=0", bullet_active);
        else passed++;
        frames(14);
        checks++;
        if (bullet_active !== 1'b0) $display("FAIL latched_wait got=%0b want=0", bullet_active);
        else passed++;
        frame();
        checks++;
        if (bullet_active !== 1'b1 || shots_fired !== 8'd4 || bullet_y !== 12'sd200)
            $display("FAIL latched_launch got=%0b,%0d,%0d want=1,4,200", bullet_active, shots_fired, bullet_y);
        else passed++;
    endtask

    task automatic test_fly_edge_ignored();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        frames(15);
        frame();
        checks++;
        if (bullet_active !== 1'b0 || shots_fired !== 8'd4)
            $display("FAIL fly_edge_dropped got=%0b,%0d want=0,4", bullet_active, shots_fired);
        else passed++;
    endtask

    task automatic test_render();
        logic signed [11:0] hv [0:6];
        logic signed [11:0] vv [0:6];
        logic               ev [0:6];
        hv = '{12'sd98, 12'sd101, 12'sd100, 12'sd97, 12'sd102, 12'sd100, 12'sd99};
        vv = '{12'sd50, 12'sd59,  12'sd55,  12'sd50, 12'sd50,  12'sd60,  12'sd49};
        ev = '{1'b1,    1'b1,     1'b1,     1'b0,    1'b0,     1'b0,     1'b0};
        player_x = 12'sd100;
        player_y = 12'sd60;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        frame();
        checks++;
        if (bullet_x !== 12'sd100 || bullet_y !== 12'sd50 || shots_fired !== 8'd5)
            $display("FAIL render_setup got=%0d,%0d,%0d want=100,50,5", bullet_x, bullet_y, shots_fired);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            hpos = hv[i];
            vpos = vv[i];
            #1;
            checks++;
            if (active !== ev[i] || {pixel[2], pixel[1], pixel[0]} !== (ev[i] ? 24'hFFFF00 : 24'h000000))
                $display("FAIL render_%0d_%0d got=%0b/%h want=%0b", hpos, vpos, active,
                         {pixel[2], pixel[1], pixel[0]}, ev[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_flight();
        hpos = 12'sd100;
        vpos = 12'sd55;
        rst = 1'b1;
        tick();
        checks++;
        if (bullet_active !== 1'b0 || shots_fired !== 8'd0 || active !== 1'b0)
            $display("FAIL reset_mid_flight got=%0b,%0d,%0b want=0,0,0", bullet_active, shots_fired, active);
        else passed++;
        rst = 1'b0;
        tick();
        fire  = 1'b1;
        fsync = 1'b1;
        tick();
        fire  = 1'b0;
        fsync = 1'b0;
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        frames(2);
        checks++;
        if (bullet_active !== 1'b0 || shots_fired !== 8'd0)
            $display("FAIL reset_drops_req got=%0b,%0d want=0,0", bullet_active, shots_fired);
        else passed++;
    endtask

`ifdef BULLET_AUTOFIRE_EN
    task automatic test_autofire();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        player_x = 12'sd200;
        player_y = 12'sd40;
        fire = 1'b1;
        frame();
        checks++;
        if (shots_fired !== 8'd1 || bullet_y !== 12'sd30)
            $display("FAIL autofire_first got=%0d,%0d want=1,30", shots_fired, bullet_y);
        else passed++;
        frames(19);
        checks++;
        if (shots_fired !== 8'd1 || bullet_active !== 1'b0)
            $display("FAIL autofire_wait got=%0d,%0b want=1,0", shots_fired, bullet_active);
        else passed++;
        frame();
        checks++;
        if (shots_fired !== 8'd2 || bullet_active !== 1'b1)
            $display("FAIL autofire_repeat got=%0d,%0b want=2,1", shots_fired, bullet_active);
        else passed++;
        fire = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst      = 1'b0;
        fsync    = 1'b0;
        hpos     = 12'sd0;
        vpos     = 12'sd0;
        fire     = 1'b0;
        player_x = 12'sd0;
        player_y = 12'sd0;
        hit      = 1'b0;
        test_reset();
        test_launch();
        test_flight();
        test_hit();
        test_fly_edge_ignored();
        test_render();
        test_reset_mid_flight();
`ifdef BULLET_AUTOFIRE_EN
        test_autofire();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
